// File: rtl/adc_scan_sar.sv
// adc_scan_sar: multi-channel scan sequencer driving an external SAR DAC/comparator.
// Latency: VALID rises N+NUM_BITS+4 cycles after the edge that samples START (N = SAMPLE_CYCLES),
//   each further enabled channel adds N+NUM_BITS+4; with ADC_SCAN_SAR_AVG_EN, 4*(N+NUM_BITS+3)+1 per channel.
// Backpressure: none; START is only honoured in IDLE, results are a one-cycle VALID strobe.
//
// Ports:
//   UserCLK     sole clock, rising edge
//   RESET       synchronous, active-high
//   START       scan request, registered and acted on only in IDLE
//   BUSY        high whenever the sequencer is not IDLE
//   VALID       one-cycle result strobe (DONE state)
//   VALUE       last result, held until replaced by the next result
//   CHANNEL     channel index belonging to VALUE
//   VALUE_top   external DAC code (the live SAR result register)
//   CMP_top     external comparator, 1 = analog input >= DAC
//   HOLD_top    sample/hold control, low = track (SAMPLE state only)
//   RESET_top   comparator/DAC reset (SETTLE and START states)
//   CH_SEL_top  external analog mux select
//   ConfigBits  [3:0] SAMPLE_CYCLES, [4 +: NUM_CH] channel enable mask
//
// Optional feature: define ADC_SCAN_SAR_AVG_EN to convert each channel four times
// and report the truncated mean.

`default_nettype none

module adc_scan_sar #(
  parameter int NUM_BITS     = 12,
  parameter int NUM_CH       = 4,
  parameter int NoConfigBits = 8
) (
  input  logic                      UserCLK,
  input  logic                      RESET,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      VALID,
  output logic [NUM_BITS-1:0]       VALUE,
  output logic [$clog2(NUM_CH)-1:0] CHANNEL,
  output logic [NUM_BITS-1:0]       VALUE_top,
  input  logic                      CMP_top,
  output logic                      HOLD_top,
  output logic                      RESET_top,
  output logic [$clog2(NUM_CH)-1:0] CH_SEL_top,
  input  logic [NoConfigBits-1:0]   ConfigBits
);

  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [NUM_BITS-1:0] MSB_ONLY = {1'b1, {(NUM_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_START,
    S_CONV,
    S_DONE
  } state_t;

  // Configuration fields
  logic [3:0]        cfg_ncyc;
  logic [NUM_CH-1:0] cfg_mask;

  assign cfg_ncyc = ConfigBits[3:0];
  assign cfg_mask = ConfigBits[4 +: NUM_CH];

  // State
  state_t                state_q,  state_d;
  logic                  start_q;
  logic [NUM_CH-1:0]     mask_q,   mask_d;
  logic [3:0]            ncyc_q,   ncyc_d;
  logic [3:0]            cnt_q,    cnt_d;
  logic [BW-1:0]         bit_q,    bit_d;
  logic [NUM_BITS-1:0]   res_q,    res_d;
  logic [CW-1:0]         ch_q,     ch_d;
  logic [NUM_BITS-1:0]   value_q,  value_d;
  logic [CW-1:0]         chan_q,   chan_d;

`ifdef ADC_SCAN_SAR_AVG_EN
  logic [NUM_BITS+1:0]   acc_q,    acc_d;
  logic [NUM_BITS+1:0]   acc_sum;
  logic [1:0]            avg_q,    avg_d;
`endif

  // Helper combinational values
  logic [CW-1:0]         first_ch;
  logic [CW-1:0]         next_ch;
  logic                  next_vld;
  logic [NUM_BITS-1:0]   trial;
  logic [BW-1:0]         bit_dn;

  // Lowest enabled channel of the live mask, used at scan start.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_mask[i]) first_ch = CW'(i);
    end
  end

  // Next enabled channel strictly above the current one in the latched mask.
  // Searching downward leaves the lowest qualifying index, so disabled
  // channels are skipped without spending any cycles on them.
  always_comb begin
    next_ch  = '0;
    next_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch  = CW'(i);
        next_vld = 1'b1;
      end
    end
  end

  // One successive-approximation step: drop the bit under test if the input
  // is below the DAC, then tentatively set the next lower bit.
  assign bit_dn = bit_q - BW'(1);

  always_comb begin
    trial = res_q;
    if (!CMP_top) trial[bit_q] = 1'b0;
    if (bit_q != '0) trial[bit_dn] = 1'b1;
  end

`ifdef ADC_SCAN_SAR_AVG_EN
  assign acc_sum = acc_q + {2'b00, trial};
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ncyc_d  = ncyc_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    res_d   = res_q;
    ch_d    = ch_q;
    value_d = value_q;
    chan_d  = chan_q;
`ifdef ADC_SCAN_SAR_AVG_EN
    acc_d   = acc_q;
    avg_d   = avg_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        res_d = '0;
        // An empty mask makes the request a no-op.
        if (start_q && (cfg_mask != '0)) begin
          mask_d  = cfg_mask;
          ncyc_d  = cfg_ncyc;
          ch_d    = first_ch;
          state_d = S_SAMPLE;
`ifdef ADC_SCAN_SAR_AVG_EN
          acc_d   = '0;
          avg_d   = '0;
`endif
        end
      end

      S_SAMPLE: begin
        cnt_d   = ncyc_q;
        res_d   = MSB_ONLY;
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        // Counter loaded with N on entry gives N+1 cycles here.
        if (cnt_q == 4'd0) state_d = S_START;
        else               cnt_d   = cnt_q - 4'd1;
      end

      S_START: begin
        bit_d   = BW'(NUM_BITS - 1);
        state_d = S_CONV;
      end

      S_CONV: begin
        res_d = trial;
        if (bit_q == '0) begin
`ifdef ADC_SCAN_SAR_AVG_EN
          if (avg_q == 2'd3) begin
            value_d = acc_sum[NUM_BITS+1:2];
            chan_d  = ch_q;
            state_d = S_DONE;
          end else begin
            acc_d   = acc_sum;
            avg_d   = avg_q + 2'd1;
            state_d = S_SAMPLE;
          end
`else
          value_d = trial;
          chan_d  = ch_q;
          state_d = S_DONE;
`endif
        end else begin
          bit_d = bit_dn;
        end
      end

      S_DONE: begin
        if (next_vld) begin
          ch_d    = next_ch;
          state_d = S_SAMPLE;
`ifdef ADC_SCAN_SAR_AVG_EN
          acc_d   = '0;
          avg_d   = '0;
`endif
        end else begin
          res_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        res_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      mask_q  <= '0;
      ncyc_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      res_q   <= '0;
      ch_q    <= '0;
      value_q <= '0;
      chan_q  <= '0;
`ifdef ADC_SCAN_SAR_AVG_EN
      acc_q   <= '0;
      avg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= START;
      mask_q  <= mask_d;
      ncyc_q  <= ncyc_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
      ch_q    <= ch_d;
      value_q <= value_d;
      chan_q  <= chan_d;
`ifdef ADC_SCAN_SAR_AVG_EN
      acc_q   <= acc_d;
      avg_q   <= avg_d;
`endif
    end
  end

  // Outputs are decoded from registered state only.
  assign BUSY       = (state_q != S_IDLE);
  assign VALID      = (state_q == S_DONE);
  assign VALUE      = value_q;
  assign CHANNEL    = chan_q;
  assign VALUE_top  = res_q;
  assign HOLD_top   = (state_q != S_SAMPLE);
  assign RESET_top  = (state_q == S_SETTLE) || (state_q == S_START);
  assign CH_SEL_top = ch_q;

endmodule

`default_nettype wire
